// File: rtl/cd4022_pkg.sv
// rtl/cd4022_pkg.sv - shared constants and Johnson code helpers for the CD4022 counter
package cd4022_pkg;

  localparam int STAGES_DEFAULT = 4;
  localparam int MAX_STAGES     = 16;

  // Johnson code reached after k counts from all-zeros (k in 0..2*stages-1)
  function automatic logic [MAX_STAGES-1:0] johnson_code(input int k, input int stages);
    logic [31:0] full_mask;
    logic [31:0] code;
    full_mask = (32'd1 << stages) - 32'd1;
    if (k < stages) begin
      code = (32'd1 << k) - 32'd1;
    end else begin
      code = full_mask & ~((32'd1 << (k - stages)) - 32'd1);
    end
    return code[MAX_STAGES-1:0];
  endfunction

  // 1 when q is one of the 2*stages codes of the legal Johnson ring
  function automatic logic johnson_legal(input logic [MAX_STAGES-1:0] q, input int stages);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 2 * stages; k++) begin
      if (q == johnson_code(k, stages)) hit = 1'b1;
    end
    return hit;
  endfunction

  // One-hot count vector for q; all-zeros for codes outside the ring
  function automatic logic [2*MAX_STAGES-1:0] johnson_decode(input logic [MAX_STAGES-1:0] q,
                                                             input int stages);
    logic [2*MAX_STAGES-1:0] onehot;
    onehot = '0;
    for (int k = 0; k < 2 * stages; k++) begin
      if (q == johnson_code(k, stages)) onehot[k] = 1'b1;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/cd4022_counter_johnson_decoder.sv
// rtl/cd4022_counter_johnson_decoder.sv - combinational Johnson state to one-hot/carry decode
module cd4022_counter_johnson_decoder
  import cd4022_pkg::*;
#(
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic [STAGES-1:0]   q,
  output logic [2*STAGES-1:0] out_onehot,
  output logic                carry,
  output logic                legal
);

  logic [2*STAGES-1:0] raw;

  // Two-input adjacent-bit decodes; each is unique only inside the legal ring
  for (genvar k = 0; k < STAGES; k++) begin : g_low
    if (k == 0) begin : g_first
      assign raw[k]          = ~q[0] & ~q[STAGES-1];
      assign raw[k + STAGES] =  q[0] &  q[STAGES-1];
    end else begin : g_rest
      assign raw[k]          =  q[k-1] & ~q[k];
      assign raw[k + STAGES] = ~q[k-1] &  q[k];
    end
  end

  // Suppress the partial decodes of a corrupted register so OUT reads all-zero
  always_comb begin
    legal      = johnson_legal(MAX_STAGES'(q), STAGES);
    out_onehot = legal ? raw : '0;
    carry      = ~q[STAGES-1];
  end

endmodule

// File: rtl/cd4022_counter.sv
// rtl/cd4022_counter.sv - divide-by-2*STAGES Johnson counter with one-hot decoded outputs
module cd4022_counter
  import cd4022_pkg::*;
#(
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                CLOCK_INHIBIT,
  output logic [2*STAGES-1:0] OUT,
  output logic                CARRY_OUT
);

  logic [STAGES-1:0] q;
  logic [STAGES-1:0] q_next;
  logic              legal;

  // Shift the ring; a code outside the ring is replaced by count 0 instead of shifting
  always_comb begin
    q_next = q;
    if (legal) begin
      q_next = {q[STAGES-2:0], ~q[STAGES-1]};
    end else begin
      q_next = '0;
    end
  end

  // State register: async clear, inhibit acts as a synchronous enable
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      q <= '0;
    end else if (!CLOCK_INHIBIT) begin
      q <= q_next;
    end
  end

  cd4022_counter_johnson_decoder #(
    .STAGES(STAGES)
  ) u_decoder (
    .q         (q),
    .out_onehot(OUT),
    .carry     (CARRY_OUT),
    .legal     (legal)
  );

endmodule

// File: tb/tb_cd4022_counter.sv
// tb/tb_cd4022_counter.sv - directed self-checking bench for cd4022_counter
module tb_cd4022_counter;

  logic       clk;
  logic       rst_n;
  logic       inhibit;
  logic [7:0] out;
  logic       carry;

  int checks;
  int errors;

  cd4022_counter #(.STAGES(4)) dut (
    .CLOCK        (clk),
    .RESET        (rst_n),
    .CLOCK_INHIBIT(inhibit),
    .OUT          (out),
    .CARRY_OUT    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    inhibit = 1'b1;
    rst_n   = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out !== 8'h01) begin
        $display("FAIL reset_out edge%0d: got %h expected 01", i, out);
        errors++;
      end
      checks++;
      if (carry !== 1'b1) begin
        $display("FAIL reset_carry edge%0d: got %b expected 1", i, carry);
        errors++;
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out !== 8'h01 || carry !== 1'b1) begin
        $display("FAIL reset_hold edge%0d: got out=%h carry=%b expected out=01 carry=1", i, out, carry);
        errors++;
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [7:0] exp_out [10];
    logic       exp_carry [10];
    exp_out   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
    exp_carry = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    inhibit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out !== exp_out[i]) begin
        $display("FAIL count_out step%0d: got %h expected %h", i, out, exp_out[i]);
        errors++;
      end
      checks++;
      if (carry !== exp_carry[i]) begin
        $display("FAIL count_carry step%0d: got %b expected %b", i, carry, exp_carry[i]);
        errors++;
      end
      checks++;
      if (!$onehot(out) || carry !== (|out[3:0])) begin
        $display("FAIL invariant step%0d: got out=%h carry=%b expected onehot and carry=|out[3:0]", i, out, carry);
        errors++;
      end
    end
  endtask

  task automatic test_inhibit();
    tick();
    checks++;
    if (out !== 8'h08) begin
      $display("FAIL inhibit_setup: got %h expected 08", out);
      errors++;
    end
    inhibit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out !== 8'h08) begin
        $display("FAIL inhibit_hold edge%0d: got %h expected 08", i, out);
        errors++;
      end
    end
    inhibit = 1'b0;
    tick();
    checks++;
    if (out !== 8'h10 || carry !== 1'b0) begin
      $display("FAIL inhibit_resume: got out=%h carry=%b expected out=10 carry=0", out, carry);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    tick();
    checks++;
    if (out !== 8'h20) begin
      $display("FAIL async_setup: got %h expected 20", out);
      errors++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 8'h01 || carry !== 1'b1) begin
      $display("FAIL async_clear: got out=%h carry=%b expected out=01 carry=1", out, carry);
      errors++;
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (out !== 8'h02) begin
      $display("FAIL async_resume: got %h expected 02", out);
      errors++;
    end
  endtask

  task automatic test_illegal_recovery();
    inhibit = 1'b0;
    force dut.q = 4'b0101;
    #1;
    checks++;
    if (out !== 8'h00 || carry !== 1'b1) begin
      $display("FAIL illegal_out: got out=%h carry=%b expected out=00 carry=1", out, carry);
      errors++;
    end
    release dut.q;
    tick();
    checks++;
    if (out !== 8'h01 || carry !== 1'b1) begin
      $display("FAIL illegal_recover: got out=%h carry=%b expected out=01 carry=1", out, carry);
      errors++;
    end
    tick();
    checks++;
    if (out !== 8'h02) begin
      $display("FAIL illegal_next: got %h expected 02", out);
      errors++;
    end
  endtask

  task automatic test_illegal_inhibited();
    inhibit = 1'b1;
    force dut.q = 4'b1010;
    #1;
    release dut.q;
    tick();
    checks++;
    if (out !== 8'h00 || carry !== 1'b0) begin
      $display("FAIL illegal_inhibit_hold: got out=%h carry=%b expected out=00 carry=0", out, carry);
      errors++;
    end
    inhibit = 1'b0;
    tick();
    checks++;
    if (out !== 8'h01 || carry !== 1'b1) begin
      $display("FAIL illegal_inhibit_recover: got out=%h carry=%b expected out=01 carry=1", out, carry);
      errors++;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    inhibit = 1'b1;
    #1;
    test_reset();
    test_count_wrap();
    test_inhibit();
    test_async_reset();
    test_illegal_recovery();
    test_illegal_inhibited();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
